rr_arbiter_timeslice: RTL and testbench

RR_ARBITER_TIMESLICE -- requirements
Module: rr_arbiter_timeslice

---
 rtl/rr_arbiter_timeslice.sv | 110 +++++++++++
 tb/tb_rr_arbiter_timeslice.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_timeslice.sv
// Round-robin arbiter with a per-grant time slice: each owner keeps the grant for
// up to slice_len cycles (latched at grant time) or until it drops its request.
module rr_arbiter_timeslice #(
    parameter int N       = 4,
    parameter int SLICE_W = 4,
    parameter int IW      = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req,
    input  logic [SLICE_W-1:0] slice_len,
    output logic [N-1:0]       gnt,
    output logic [IW-1:0]      gnt_id,
    output logic               gnt_vld,
    output logic               slice_exp
);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_BUSY = 1'b1;

    logic               state_reg,   state_next;
    logic [IW-1:0]      ptr_reg,     ptr_next;
    logic [N-1:0]       gnt_reg,     gnt_next;
    logic [IW-1:0]      gnt_id_reg,  gnt_id_next;
    logic [SLICE_W-1:0] cnt_reg,     cnt_next;
    logic [SLICE_W-1:0] slice_q_reg, slice_q_next;

    logic               found;
    logic [IW-1:0]      pick;
    logic [IW-1:0]      cand;
    logic [N-1:0]       pick_onehot;
    logic               owner_req;
    logic               turn_end;
    logic [SLICE_W-1:0] slice_eff;

    // Search starts just after the last owner; the last owner itself is checked last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr_reg) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign pick_onehot[gi] = (pick == IW'(gi));
        end
    endgenerate

    assign owner_req = req[gnt_id_reg];
    assign turn_end  = !owner_req || (cnt_reg == slice_q_reg);
    assign slice_eff = (slice_len == '0) ? SLICE_W'(1) : slice_len;

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        gnt_next     = gnt_reg;
        gnt_id_next  = gnt_id_reg;
        cnt_next     = cnt_reg;
        slice_q_next = slice_q_reg;
        if (state_reg == STATE_IDLE || turn_end) begin
            if (found) begin
                state_next   = STATE_BUSY;
                gnt_next     = pick_onehot;
                gnt_id_next  = pick;
                ptr_next     = pick;
                cnt_next     = SLICE_W'(1);
                slice_q_next = slice_eff;
            end else begin
                // Nobody requesting: park in IDLE but keep ptr for fairness.
                state_next  = STATE_IDLE;
                gnt_next    = '0;
                gnt_id_next = '0;
                cnt_next    = '0;
            end
        end else begin
            cnt_next = cnt_reg + SLICE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= STATE_IDLE;
            ptr_reg     <= IW'(N - 1);
            gnt_reg     <= '0;
            gnt_id_reg  <= '0;
            cnt_reg     <= '0;
            slice_q_reg <= SLICE_W'(1);
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            gnt_reg     <= gnt_next;
            gnt_id_reg  <= gnt_id_next;
            cnt_reg     <= cnt_next;
            slice_q_reg <= slice_q_next;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_id    = gnt_id_reg;
    assign gnt_vld   = (state_reg == STATE_BUSY);
    assign slice_exp = (state_reg == STATE_BUSY) && (cnt_reg == slice_q_reg) && owner_req;

endmodule

// File: tb/tb_rr_arbiter_timeslice.sv
// Directed bench for rr_arbiter_timeslice (N=4, SLICE_W=4); each task covers one scenario.
module tb_rr_arbiter_timeslice;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] slice_len;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic       slice_exp;

    int errors = 0;
    int checks = 0;

    rr_arbiter_timeslice #(.N(4), .SLICE_W(4), .IW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .slice_len (slice_len),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_vld   (gnt_vld),
        .slice_exp (slice_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rr_gnt  [10] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
    logic       rr_exp  [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] chg_gnt [8]  = '{4'b0001, 4'b0001, 4'b0010, 4'b0010,
                                 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    logic       chg_exp [8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req       = 4'b0000;
        slice_len = 4'd1;
        #1;
        checks++;
        if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_id !== 2'd0 || slice_exp !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b vld=%b id=%0d exp=%b expected 0000 0 0 0",
                     gnt, gnt_vld, gnt_id, slice_exp);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_noreq: gnt=%b vld=%b expected 0000 0", gnt, gnt_vld);
        end
        $display("test_reset done: gnt=%b vld=%b", gnt, gnt_vld);
    endtask

    task automatic test_single_expiry();
        do_reset();
        slice_len = 4'd3;
        req       = 4'b0001;
        for (int i = 1; i <= 9; i++) begin
            step();
            $display("single cycle %0d: gnt=%b exp=%b", i, gnt, slice_exp);
            checks++;
            if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_vld !== 1'b1) begin
                errors++;
                $display("FAIL single_gnt[%0d]: gnt=%b id=%0d vld=%b expected 0001 0 1",
                         i, gnt, gnt_id, gnt_vld);
            end
            checks++;
            if (slice_exp !== (i % 3 == 0)) begin
                errors++;
                $display("FAIL single_exp[%0d]: slice_exp=%b expected %b", i, slice_exp, (i % 3 == 0));
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        slice_len = 4'd2;
        req       = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            step();
            $display("rr cycle %0d: gnt=%b exp=%b", i, gnt, slice_exp);
            checks++;
            if (gnt !== rr_gnt[i] || slice_exp !== rr_exp[i]) begin
                errors++;
                $display("FAIL rr[%0d]: gnt=%b exp=%b expected %b %b",
                         i, gnt, slice_exp, rr_gnt[i], rr_exp[i]);
            end
        end
    endtask

    task automatic test_release();
        do_reset();
        slice_len = 4'd4;
        req       = 4'b0011;
        step();
        step();
        checks++;
        if (gnt !== 4'b0001 || slice_exp !== 1'b0) begin
            errors++;
            $display("FAIL release_pre: gnt=%b exp=%b expected 0001 0", gnt, slice_exp);
        end
        req = 4'b0010;
        #1;
        checks++;
        if (slice_exp !== 1'b0 || gnt !== 4'b0001) begin
            errors++;
            $display("FAIL release_drop: gnt=%b exp=%b expected 0001 0", gnt, slice_exp);
        end
        step();
        $display("release: gnt=%b id=%0d exp=%b", gnt, gnt_id, slice_exp);
        checks++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1 || slice_exp !== 1'b0) begin
            errors++;
            $display("FAIL release_handoff: gnt=%b id=%0d exp=%b expected 0010 1 0",
                     gnt, gnt_id, slice_exp);
        end
    endtask

    task automatic test_zero_slice();
        do_reset();
        slice_len = 4'd0;
        req       = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            step();
            $display("zero_slice cycle %0d: gnt=%b exp=%b", i, gnt, slice_exp);
            checks++;
            if (gnt !== ((i % 2 == 0) ? 4'b0001 : 4'b0100) || slice_exp !== 1'b1) begin
                errors++;
                $display("FAIL zero_slice[%0d]: gnt=%b exp=%b expected %b 1",
                         i, gnt, slice_exp, (i % 2 == 0) ? 4'b0001 : 4'b0100);
            end
        end
    endtask

    task automatic test_slice_change();
        do_reset();
        slice_len = 4'd2;
        req       = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) slice_len = 4'd5;
            $display("slice_change cycle %0d: gnt=%b exp=%b", i, gnt, slice_exp);
            checks++;
            if (gnt !== chg_gnt[i] || slice_exp !== chg_exp[i]) begin
                errors++;
                $display("FAIL slice_change[%0d]: gnt=%b exp=%b expected %b %b",
                         i, gnt, slice_exp, chg_gnt[i], chg_exp[i]);
            end
        end
    endtask

    task automatic test_idle_and_ptr();
        do_reset();
        slice_len = 4'd3;
        req       = 4'b0010;
        step();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL idle_first: gnt=%b expected 0010", gnt);
        end
        req = 4'b0000;
        step();
        checks++;
        if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || slice_exp !== 1'b0) begin
            errors++;
            $display("FAIL idle_enter: gnt=%b vld=%b exp=%b expected 0000 0 0", gnt, gnt_vld, slice_exp);
        end
        req = 4'b0101;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL no_comb_path: gnt=%b expected 0000", gnt);
        end
        step();
        $display("idle_ptr: gnt=%b id=%0d", gnt, gnt_id);
        checks++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2 || gnt_vld !== 1'b1) begin
            errors++;
            $display("FAIL ptr_retained: gnt=%b id=%0d vld=%b expected 0100 2 1", gnt, gnt_id, gnt_vld);
        end
    endtask

    task automatic test_reset_mid_slice();
        do_reset();
        slice_len = 4'd4;
        req       = 4'b0100;
        step();
        req = 4'b1000;
        step();
        step();
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_pre: gnt=%b expected 1000", gnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_id !== 2'd0 || slice_exp !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: gnt=%b vld=%b id=%0d exp=%b expected 0000 0 0 0",
                     gnt, gnt_vld, gnt_id, slice_exp);
        end
        req = 4'b1001;
        step();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_held: gnt=%b expected 0000", gnt);
        end
        rst_n = 1'b1;
        step();
        $display("reset_mid_slice: gnt=%b id=%0d", gnt, gnt_id);
        checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL midrst_restart: gnt=%b id=%0d expected 0001 0", gnt, gnt_id);
        end
    endtask

    initial begin
        test_reset();
        test_single_expiry();
        test_round_robin();
        test_release();
        test_zero_slice();
        test_slice_change();
        test_idle_and_ptr();
        test_reset_mid_slice();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
